// File: rtl/udm_bus_arbiter_if.sv
// One req/ack/resp bus segment. The master modport drives the request side
// and the slave modport answers with accept, response and read data.
interface udm_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/udm_bus_arbiter.sv
// Two-master arbiter sharing one slave bus between the UDM debug master (m0)
// and a second master (m1); in-order read responses are routed via an ID FIFO.
module udm_bus_arbiter #(
    parameter string PRIO_MODE       = "RR",
    parameter int    RESP_FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    udm_bus_arbiter_if.slave        m0,
    udm_bus_arbiter_if.slave        m1,
    udm_bus_arbiter_if.master       s,
    output logic                    err_o
);

    localparam bit PRIO_RR = (PRIO_MODE == "RR");
    localparam int AW      = (RESP_FIFO_DEPTH > 2) ? $clog2(RESP_FIFO_DEPTH) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic          g;
    logic          lw;

    logic          id_mem [RESP_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          in_grant;
    logic          mg_req;
    logic          mg_we;
    logic          fifo_empty;
    logic          fifo_full;
    logic          head;
    logic          pop;
    logic          push;
    logic          done;
    logic          pick;

    assign in_grant   = (state == GRANT);
    assign mg_req     = g ? m1.req : m0.req;
    assign mg_we      = g ? m1.we  : m0.we;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(RESP_FIFO_DEPTH));
    assign head       = id_mem[rd_ptr];
    assign pop        = s.resp & ~fifo_empty;

    // A response freeing a slot this very cycle lets a held read proceed.
    assign s.req      = in_grant & mg_req & (mg_we | ~fifo_full | pop);
    assign done       = s.req & s.ack;
    assign push       = done & ~mg_we;

    assign m0.ack     = done & ~g;
    assign m1.ack     = done &  g;
    assign m0.resp    = pop & ~head;
    assign m1.resp    = pop &  head;
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;

    // Contention resolves to the master that did not win last (RR) or to m0.
    assign pick = (m0.req & m1.req) ? (PRIO_RR ? ~lw : 1'b0) : m1.req;

    // NOTE: every output gets a default before the branch, so no latch is inferred.
    always_comb begin
        s.we    = 1'b0;
        s.addr  = '0;
        s.be    = '0;
        s.wdata = '0;
        if (in_grant) begin
            s.we    = mg_we;
            s.addr  = g ? m1.addr  : m0.addr;
            s.be    = g ? m1.be    : m0.be;
            s.wdata = g ? m1.wdata : m0.wdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            g      <= 1'b0;
            lw     <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.req | m1.req) begin
                        g     <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!mg_req) begin
                        state <= IDLE;
                    end else if (done) begin
                        lw    <= g;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (s.resp && fifo_empty) err_o <= 1'b1;
        end
    end

    // NOTE: the ID storage has no reset; the pointers and count alone define
    // which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr] <= g;
    end

endmodule

// File: tb/tb_udm_bus_arbiter.sv
// Self-checking bench for udm_bus_arbiter: directed scenarios on RR and FIXED
// instances, then randomized traffic against a transaction-level scoreboard.
module tb_udm_bus_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    logic        s_ack;
    logic        s_resp;
    logic [31:0] s_rdata;
    logic        rr_err;
    logic        fx_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    udm_bus_arbiter_if rr_m0 ();
    udm_bus_arbiter_if rr_m1 ();
    udm_bus_arbiter_if rr_s ();
    udm_bus_arbiter_if fx_m0 ();
    udm_bus_arbiter_if fx_m1 ();
    udm_bus_arbiter_if fx_s ();

    assign rr_m0.req = m_req[0];  assign rr_m0.we = m_we[0];  assign rr_m0.addr = m_addr[0];
    assign rr_m0.be  = m_be[0];   assign rr_m0.wdata = m_wdata[0];
    assign rr_m1.req = m_req[1];  assign rr_m1.we = m_we[1];  assign rr_m1.addr = m_addr[1];
    assign rr_m1.be  = m_be[1];   assign rr_m1.wdata = m_wdata[1];
    assign rr_s.ack  = s_ack;     assign rr_s.resp = s_resp;  assign rr_s.rdata = s_rdata;

    assign fx_m0.req = m_req[0];  assign fx_m0.we = m_we[0];  assign fx_m0.addr = m_addr[0];
    assign fx_m0.be  = m_be[0];   assign fx_m0.wdata = m_wdata[0];
    assign fx_m1.req = m_req[1];  assign fx_m1.we = m_we[1];  assign fx_m1.addr = m_addr[1];
    assign fx_m1.be  = m_be[1];   assign fx_m1.wdata = m_wdata[1];
    assign fx_s.ack  = s_ack;     assign fx_s.resp = s_resp;  assign fx_s.rdata = s_rdata;

    udm_bus_arbiter #(.PRIO_MODE("RR"), .RESP_FIFO_DEPTH(DEPTH)) dut_rr (
        .clk_i (clk), .rst_i (rst), .m0 (rr_m0), .m1 (rr_m1), .s (rr_s), .err_o (rr_err)
    );

    udm_bus_arbiter #(.PRIO_MODE("FIXED"), .RESP_FIFO_DEPTH(DEPTH)) dut_fx (
        .clk_i (clk), .rst_i (rst), .m0 (fx_m0), .m1 (fx_m1), .s (fx_s), .err_o (fx_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_req   = '0;
        m_we    = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            m_addr[k]  = '0;
            m_wdata[k] = '0;
            m_be[k]    = '0;
        end
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        to_sample();
        to_drive();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acks;
        int  q[$];
        bit  err_exp;
        bit  acked[2];
        int  wait_cnt[2];
        logic a0, a1, e0, e1, src_ok;

        clear_inputs();
        rst = 1'b1;
        to_drive();
        to_sample();
        check("rst_sreq", rr_s.req, 0);
        check("rst_saddr", rr_s.addr, 0);
        check("rst_acks", {rr_m0.ack, rr_m1.ack}, 0);
        check("rst_resps", {rr_m0.resp, rr_m1.resp}, 0);
        to_drive();
        rst = 1'b0;
        to_sample();
        check("rst_err", rr_err, 0);
        to_drive();

        // Single m0 write, slave acks immediately.
        reset_dut();
        m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 32'h10;
        m_wdata[0] = 32'hDEADBEEF; m_be[0] = 4'hF; s_ack = 1'b1;
        to_sample();
        check("t1_idle_sreq", rr_s.req, 0);
        to_drive();
        to_sample();
        check("t1_sreq", rr_s.req, 1);
        check("t1_swe", rr_s.we, 1);
        check("t1_saddr", rr_s.addr, 32'h10);
        check("t1_swdata", rr_s.wdata, 32'hDEADBEEF);
        check("t1_sbe", rr_s.be, 4'hF);
        check("t1_m0_ack", rr_m0.ack, 1);
        check("t1_m1_ack", rr_m1.ack, 0);
        to_drive();
        m_req[0] = 1'b0;
        to_sample();
        check("t1_sreq_drop", rr_s.req, 0);
        check("t1_m0_ack_drop", rr_m0.ack, 0);
        to_drive();

        // Both masters read continuously under RR: grants alternate from m0.
        reset_dut();
        m_req = 2'b11; m_we = 2'b00; m_addr[0] = 32'h100; m_addr[1] = 32'h200; s_ack = 1'b1;
        acks = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            to_sample();
            if (rr_m0.ack || rr_m1.ack) begin
                check("t2_grant_idx", 32'(rr_m1.ack), 32'(acks % 2));
                check("t2_single_ack", rr_m0.ack & rr_m1.ack, 0);
                check("t2_saddr", rr_s.addr, (acks % 2 == 1) ? 32'h200 : 32'h100);
                acks++;
            end
            to_drive();
        end
        check("t2_ack_count", acks, 4);
        m_req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            s_resp = 1'b1;
            s_rdata = 32'(k + 1);
            to_sample();
            check("t2_m0_resp", rr_m0.resp, 32'(k % 2 == 0));
            check("t2_m1_resp", rr_m1.resp, 32'(k % 2 == 1));
            check("t2_m0_rdata", rr_m0.rdata, 32'(k + 1));
            check("t2_m1_rdata", rr_m1.rdata, 32'(k + 1));
            to_drive();
        end
        s_resp = 1'b0;

        // FIXED: m0 keeps winning while it requests; m1 goes next once m0 drops.
        reset_dut();
        m_req = 2'b11; m_we = 2'b11; m_addr[0] = 32'h300; m_addr[1] = 32'h400; s_ack = 1'b1;
        acks = 0;
        for (int c = 0; c < 20 && acks < 3; c++) begin
            to_sample();
            check("t3_m1_blocked", fx_m1.ack, 0);
            if (fx_m0.ack) acks++;
            to_drive();
        end
        check("t3_m0_ack_count", acks, 3);
        m_req[0] = 1'b0;
        to_sample();
        check("t3_m1_arbitrate", fx_m1.ack, 0);
        to_drive();
        to_sample();
        check("t3_m1_ack", fx_m1.ack, 1);
        check("t3_m1_addr", fx_s.addr, 32'h400);
        to_drive();
        m_req = 2'b00;

        // Five reads with responses withheld: the fifth waits for a free slot.
        reset_dut();
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h40; s_ack = 1'b1;
        acks = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            to_sample();
            if (rr_m0.ack) acks++;
            to_drive();
        end
        check("t4_ack_count", acks, 4);
        to_sample();
        check("t4_idle_sreq", rr_s.req, 0);
        to_drive();
        for (int c = 0; c < 3; c++) begin
            to_sample();
            check("t4_full_sreq", rr_s.req, 0);
            check("t4_full_ack", rr_m0.ack, 0);
            to_drive();
        end
        s_resp = 1'b1; s_rdata = 32'hA5A5;
        to_sample();
        check("t4_freed_sreq", rr_s.req, 1);
        check("t4_freed_ack", rr_m0.ack, 1);
        check("t4_freed_resp", rr_m0.resp, 1);
        to_drive();
        m_req = 2'b00; s_resp = 1'b0;

        // Response with nothing outstanding sets the sticky error.
        reset_dut();
        s_resp = 1'b1; s_rdata = 32'h77;
        to_sample();
        check("t5_no_resp", {rr_m0.resp, rr_m1.resp}, 0);
        check("t5_err_before", rr_err, 0);
        to_drive();
        s_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            to_sample();
            check("t5_err_sticky", rr_err, 1);
            to_drive();
        end
        reset_dut();
        to_sample();
        check("t5_err_cleared", rr_err, 0);
        to_drive();

        // Reset with two reads outstanding flushes the ID FIFO.
        reset_dut();
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h80; s_ack = 1'b1;
        acks = 0;
        for (int c = 0; c < 10 && acks < 2; c++) begin
            to_sample();
            if (rr_m0.ack) acks++;
            to_drive();
        end
        check("t6_ack_count", acks, 2);
        reset_dut();
        s_rdata = 32'h1234;
        to_sample();
        check("t6_sreq", rr_s.req, 0);
        check("t6_saddr", rr_s.addr, 0);
        check("t6_acks", {rr_m0.ack, rr_m1.ack}, 0);
        check("t6_err", rr_err, 0);
        check("t6_rdata", rr_m0.rdata, 32'h1234);
        to_drive();
        s_resp = 1'b1;
        to_sample();
        check("t6_resp_flushed", {rr_m0.resp, rr_m1.resp}, 0);
        to_drive();
        s_resp = 1'b0;
        to_sample();
        check("t6_err_set", rr_err, 1);
        to_drive();

        // Randomized traffic against a transaction-level scoreboard.
        reset_dut();
        err_exp = 1'b0;
        acked = '{1'b0, 1'b0};
        wait_cnt = '{0, 0};
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_req[k] || acked[k]) begin
                    m_req[k]   = 1'($urandom_range(0, 1));
                    m_we[k]    = 1'($urandom_range(0, 1));
                    m_addr[k]  = $urandom;
                    m_wdata[k] = $urandom;
                    m_be[k]    = 4'($urandom_range(0, 15));
                end
            end
            s_ack   = ($urandom_range(0, 3) != 0);
            s_resp  = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            to_sample();

            a0 = rr_m0.ack;
            a1 = rr_m1.ack;
            check("rnd_err", rr_err, err_exp);
            check("rnd_rdata", rr_m1.rdata, s_rdata);
            check("rnd_one_ack", a0 & a1, 0);
            check("rnd_ack_rule", a0 | a1, s_ack & rr_s.req);
            if (rr_s.req) begin
                src_ok = (m_req[0] && rr_s.addr == m_addr[0] && rr_s.we == m_we[0]) ||
                         (m_req[1] && rr_s.addr == m_addr[1] && rr_s.we == m_we[1]);
                check("rnd_sreq_src", src_ok, 1);
            end
            for (int k = 0; k < 2; k++) begin
                if ((k == 0) ? a0 : a1) begin
                    check("rnd_ack_req", m_req[k], 1);
                    check("rnd_ack_addr", rr_s.addr, m_addr[k]);
                    check("rnd_ack_we", rr_s.we, m_we[k]);
                    check("rnd_ack_be", rr_s.be, m_be[k]);
                    check("rnd_ack_wdata", rr_s.wdata, m_wdata[k]);
                end
            end

            e0 = s_resp && q.size() > 0 && q[0] == 0;
            e1 = s_resp && q.size() > 0 && q[0] == 1;
            check("rnd_m0_resp", rr_m0.resp, e0);
            check("rnd_m1_resp", rr_m1.resp, e1);
            if (s_resp) begin
                if (q.size() > 0) void'(q.pop_front());
                else              err_exp = 1'b1;
            end
            if (a0 && !m_we[0]) q.push_back(0);
            if (a1 && !m_we[1]) q.push_back(1);
            if (a0 || a1) check("rnd_fifo_bound", q.size() <= DEPTH, 1);

            acked[0] = a0;
            acked[1] = a1;
            for (int k = 0; k < 2; k++) begin
                wait_cnt[k] = (m_req[k] && !acked[k]) ? wait_cnt[k] + 1 : 0;
                if (m_req[k]) check("rnd_starve", wait_cnt[k] > 60, 0);
            end
            to_drive();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
